// File: rtl/dec_fp_pkg.sv
// Shared decimal floating-point constants: BCD digit width, digit literals,
// rounding-mode encodings and the round-up decision used by the rounding unit.
package dec_fp_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_NINE    = 4'h9;
  localparam logic [3:0] BCD_ONE     = 4'h1;
  localparam logic [3:0] BCD_FIVE    = 4'h5;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RNA = 3'd1,
    RM_RTZ = 3'd2,
    RM_RUP = 3'd3,
    RM_RDN = 3'd4
  } rnd_mode_e;

  // Unused encodings fall through to round-to-nearest-even.
  function automatic logic round_up(input logic [2:0] mode, input logic [3:0] rnd,
                                    input logic sticky, input logic lsd_odd,
                                    input logic sign);
    logic inexact;
    logic up;
    inexact = (rnd != 4'h0) || sticky;
    case (mode)
      RM_RNA:  up = (rnd >= BCD_FIVE);
      RM_RTZ:  up = 1'b0;
      RM_RUP:  up = inexact && !sign;
      RM_RDN:  up = inexact && sign;
      default: up = (rnd > BCD_FIVE) || ((rnd == BCD_FIVE) && (sticky || lsd_odd));
    endcase
    return up;
  endfunction

endpackage

// File: rtl/bcd_incrementer.sv
// Adds a single increment to a packed BCD significand; cout flags the
// all-nines wrap to zero.
module bcd_incrementer
  import dec_fp_pkg::*;
#(
  parameter int DIGITS = 7
) (
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
  input  logic                          inc,
  output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
  output logic                          cout
);

  logic carry;

  // NOTE: 'carry' ripples digit to digit inside one evaluation, so it must use
  // blocking assignments here; sequential state uses non-blocking only.
  always_comb begin
    carry = inc;
    sum   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry && (a[i*BCD_DIGIT_W +: BCD_DIGIT_W] == BCD_NINE)) begin
        sum[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'h0;
      end else begin
        sum[i*BCD_DIGIT_W +: BCD_DIGIT_W] = a[i*BCD_DIGIT_W +: BCD_DIGIT_W] + {3'b000, carry};
        carry = 1'b0;
      end
    end
    cout = carry;
  end

endmodule

// File: rtl/decimal_round_unit.sv
// Two-stage BCD rounding unit: S1 normalises the adder carry and decides the
// round-up, S2 applies the increment. Define DRU_INEXACT_CNT_EN for the counter.
module decimal_round_unit
  import dec_fp_pkg::*;
#(
  parameter int DIGITS     = 7,
  parameter int GRS_DIGITS = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [4*DIGITS-1:0]            in_sig,
  input  logic [4*GRS_DIGITS-1:0]        in_grs,
  input  logic [3:0]                     in_cout,
  input  logic                           in_sign,
  input  logic [2:0]                     in_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [4*DIGITS-1:0]            out_sig,
  output logic [1:0]                     out_exp_inc,
  output logic                           out_inexact,
  output logic [15:0]                    inexact_cnt
);

  localparam int SW = BCD_DIGIT_W * DIGITS;
  localparam int GW = BCD_DIGIT_W * GRS_DIGITS;

  logic          s1_valid_q, s1_valid_d;
  logic [SW-1:0] s1_sig_q, s1_sig_d;
  logic          s1_inc_q, s1_inc_d;
  logic          s1_shift_q, s1_shift_d;
  logic          s1_inexact_q, s1_inexact_d;
  logic          s2_valid_q, s2_valid_d;
  logic [SW-1:0] out_sig_q, out_sig_d;
  logic [1:0]    out_exp_inc_q, out_exp_inc_d;
  logic          out_inexact_q, out_inexact_d;

  logic          shift, lost_nz, sticky, inexact, round_inc;
  logic [SW-1:0] norm_sig;
  logic [GW-1:0] rem;
  logic [3:0]    rnd_digit;
  logic          s1_adv, accept, s2_load;
  logic [SW-1:0] inc_sum;
  logic          inc_cout;

  // A carry digit of one pushes every digit down one place; the grs LSD drops
  // off the end but must still count toward sticky.
  // NOTE: every output of this block gets a value on every path, so no latch.
  always_comb begin
    shift     = (in_cout == BCD_ONE);
    norm_sig  = in_sig;
    rem       = in_grs;
    lost_nz   = 1'b0;
    if (shift) begin
      norm_sig = {in_cout, in_sig[SW-1:BCD_DIGIT_W]};
      rem      = {in_sig[BCD_DIGIT_W-1:0], in_grs[GW-1:BCD_DIGIT_W]};
      lost_nz  = |in_grs[BCD_DIGIT_W-1:0];
    end
    rnd_digit = rem[GW-1 -: BCD_DIGIT_W];
    sticky    = (|rem[GW-BCD_DIGIT_W-1:0]) || lost_nz;
    inexact   = (rnd_digit != 4'h0) || sticky;
    round_inc = round_up(in_mode, rnd_digit, sticky, norm_sig[0], in_sign);
  end

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s1_adv;

  bcd_incrementer #(.DIGITS(DIGITS)) u_inc (
    .a    (s1_sig_q),
    .inc  (s1_inc_q),
    .sum  (inc_sum),
    .cout (inc_cout)
  );

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_sig_d      = s1_sig_q;
    s1_inc_d      = s1_inc_q;
    s1_shift_d    = s1_shift_q;
    s1_inexact_d  = s1_inexact_q;
    s2_valid_d    = s2_valid_q;
    out_sig_d     = out_sig_q;
    out_exp_inc_d = out_exp_inc_q;
    out_inexact_d = out_inexact_q;
    if (in_ready) s1_valid_d = in_valid;
    if (accept) begin
      s1_sig_d     = norm_sig;
      s1_inc_d     = round_inc;
      s1_shift_d   = shift;
      s1_inexact_d = inexact;
    end
    if (s1_adv) s2_valid_d = s1_valid_q;
    // Output registers only move on a real transfer so a stalled result holds.
    if (s2_load) begin
      out_sig_d     = inc_cout ? {BCD_ONE, {(SW-BCD_DIGIT_W){1'b0}}} : inc_sum;
      out_exp_inc_d = {1'b0, s1_shift_q} + {1'b0, inc_cout};
      out_inexact_d = s1_inexact_q;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_sig_q      <= '0;
      s1_inc_q      <= 1'b0;
      s1_shift_q    <= 1'b0;
      s1_inexact_q  <= 1'b0;
      s2_valid_q    <= 1'b0;
      out_sig_q     <= '0;
      out_exp_inc_q <= '0;
      out_inexact_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_sig_q      <= s1_sig_d;
      s1_inc_q      <= s1_inc_d;
      s1_shift_q    <= s1_shift_d;
      s1_inexact_q  <= s1_inexact_d;
      s2_valid_q    <= s2_valid_d;
      out_sig_q     <= out_sig_d;
      out_exp_inc_q <= out_exp_inc_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_sig     = out_sig_q;
  assign out_exp_inc = out_exp_inc_q;
  assign out_inexact = out_inexact_q;

`ifdef DRU_INEXACT_CNT_EN
  logic [15:0] inexact_cnt_q, inexact_cnt_d;

  always_comb begin
    inexact_cnt_d = inexact_cnt_q;
    if (s2_valid_q && out_ready && out_inexact_q && (inexact_cnt_q != 16'hFFFF))
      inexact_cnt_d = inexact_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inexact_cnt_q <= '0;
    else        inexact_cnt_q <= inexact_cnt_d;
  end

  assign inexact_cnt = inexact_cnt_q;
`else
  assign inexact_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_decimal_round_unit.sv
// Directed scoreboard bench for decimal_round_unit (DIGITS=7, GRS_DIGITS=3):
// rounding modes, carry normalisation, overflow, backpressure and mid-flight reset.
module tb_decimal_round_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [27:0] in_sig;
  logic [11:0] in_grs;
  logic [3:0]  in_cout;
  logic        in_sign;
  logic [2:0]  in_mode;
  logic        out_valid, out_ready;
  logic [27:0] out_sig;
  logic [1:0]  out_exp_inc;
  logic        out_inexact;
  logic [15:0] inexact_cnt;

  typedef struct packed {
    logic [27:0] sig;
    logic [1:0]  exp_inc;
    logic        inexact;
  } exp_t;

  typedef struct packed {
    logic [2:0]  mode;
    logic        sign;
    logic [3:0]  cout;
    logic [27:0] sig;
    logic [11:0] grs;
    exp_t        res;
  } vec_t;

  exp_t sb[$];
  int   total  = 0;
  int   failed = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  decimal_round_unit #(.DIGITS(7), .GRS_DIGITS(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sig      (in_sig),
    .in_grs      (in_grs),
    .in_cout     (in_cout),
    .in_sign     (in_sign),
    .in_mode     (in_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sig     (out_sig),
    .out_exp_inc (out_exp_inc),
    .out_inexact (out_inexact),
    .inexact_cnt (inexact_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: samples settled values between the drive point and the next edge.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_sig", {4'h0, out_sig}, {4'h0, e.sig});
        check("out_exp_inc", {30'd0, out_exp_inc}, {30'd0, e.exp_inc});
        check("out_inexact", {31'd0, out_inexact}, {31'd0, e.inexact});
`ifdef DRU_INEXACT_CNT_EN
        if (e.inexact && exp_cnt < 65535) exp_cnt++;
`endif
      end
    end
  end

  task automatic drive(input vec_t v);
    in_mode  = v.mode;
    in_sign  = v.sign;
    in_cout  = v.cout;
    in_sig   = v.sig;
    in_grs   = v.grs;
    in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    int budget = 0;
    @(negedge clk);
    drive(v);
    #1;
    while (in_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (in_ready !== 1'b1) check("in_ready_timeout", 32'd0, 32'd1);
    sb.push_back(v.res);
    @(posedge clk);
  endtask

  task automatic drain();
    int budget = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (sb.size() != 0 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    #3;
    check("drain_empty", sb.size(), 32'd0);
  endtask

  function automatic vec_t mk(input logic [2:0] mode, input logic sign, input logic [3:0] cout,
                              input logic [27:0] sig, input logic [11:0] grs,
                              input logic [27:0] esig, input logic [1:0] einc, input logic einx);
    vec_t v;
    v.mode = mode; v.sign = sign; v.cout = cout; v.sig = sig; v.grs = grs;
    v.res.sig = esig; v.res.exp_inc = einc; v.res.inexact = einx;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sig    = '0;
    in_grs    = '0;
    in_cout   = '0;
    in_sign   = 1'b0;
    in_mode   = '0;
    out_ready = 1'b1;

    // Reference results are worked by hand from the rounding rules.
    vecs.push_back(mk(3'd0, 0, 4'h0, 28'h1234567, 12'h500, 28'h1234568, 2'd0, 1));
    vecs.push_back(mk(3'd0, 0, 4'h0, 28'h1234568, 12'h500, 28'h1234568, 2'd0, 1));
    vecs.push_back(mk(3'd1, 0, 4'h0, 28'h9999999, 12'h600, 28'h1000000, 2'd1, 1));
    vecs.push_back(mk(3'd2, 0, 4'h1, 28'h1234567, 12'h000, 28'h1123456, 2'd1, 1));
    vecs.push_back(mk(3'd3, 0, 4'h0, 28'h0000001, 12'h001, 28'h0000002, 2'd0, 1));
    vecs.push_back(mk(3'd3, 1, 4'h0, 28'h0000001, 12'h001, 28'h0000001, 2'd0, 1));
    vecs.push_back(mk(3'd4, 1, 4'h0, 28'h0000001, 12'h001, 28'h0000002, 2'd0, 1));
    vecs.push_back(mk(3'd0, 0, 4'h0, 28'h1234568, 12'h501, 28'h1234569, 2'd0, 1));
    vecs.push_back(mk(3'd0, 0, 4'h0, 28'h0000005, 12'h000, 28'h0000005, 2'd0, 0));
    vecs.push_back(mk(3'd0, 0, 4'h1, 28'h1234565, 12'h001, 28'h1123457, 2'd1, 1));
    vecs.push_back(mk(3'd0, 0, 4'h1, 28'h1234565, 12'h000, 28'h1123456, 2'd1, 1));
    vecs.push_back(mk(3'd0, 0, 4'h1, 28'h9999999, 12'h500, 28'h2000000, 2'd1, 1));
    vecs.push_back(mk(3'd2, 0, 4'h0, 28'h9999999, 12'h999, 28'h9999999, 2'd0, 1));
    vecs.push_back(mk(3'd4, 0, 4'h0, 28'h0000001, 12'h001, 28'h0000001, 2'd0, 1));
    vecs.push_back(mk(3'd7, 0, 4'h0, 28'h0000003, 12'h500, 28'h0000004, 2'd0, 1));

    // Reset state.
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_sig", {4'h0, out_sig}, 32'd0);
    check("rst_exp_inc", {30'd0, out_exp_inc}, 32'd0);
    check("rst_inexact", {31'd0, out_inexact}, 32'd0);
    check("rst_cnt", {16'd0, inexact_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two-cycle latency on the first operand.
    send(vecs[0]);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("latency_c1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    check("latency_c2", {31'd0, out_valid}, 32'd1);

    for (int i = 1; i < vecs.size(); i++) send(vecs[i]);
    drain();

    // Backpressure: third operand must stall until the consumer resumes.
    @(negedge clk);
    out_ready = 1'b0;
    send(vecs[2]);
    send(vecs[3]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) drive(vecs[4]);
      #1;
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_sig", {4'h0, out_sig}, {4'h0, vecs[2].res.sig});
      check("bp_hold_exp", {30'd0, out_exp_inc}, {30'd0, vecs[2].res.exp_inc});
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
    sb.push_back(vecs[4].res);
    @(posedge clk);
    drain();
    @(negedge clk);
    #1;
    check("cnt_value", {16'd0, inexact_cnt}, exp_cnt);

    // Reset with both stages full discards the in-flight operands.
    out_ready = 1'b0;
    send(vecs[6]);
    send(vecs[7]);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("full_before_rst", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_cnt", {16'd0, inexact_cnt}, 32'd0);
    check("midrst_out_sig", {4'h0, out_sig}, 32'd0);
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(vecs[14]);
    drain();
    @(negedge clk);
    #1;
    check("post_rst_cnt", {16'd0, inexact_cnt}, exp_cnt);

    $display("%0d/%0d checks passed", total - failed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/decimal_round_unit.md
DECIMAL_ROUND_UNIT -- requirements
Module: decimal_round_unit

Interface
REQ-001 SHALL have parameter DIGITS, default 7, meaning significand length in BCD digits (legal 2..34).
REQ-002 SHALL have parameter GRS_DIGITS, default 3, meaning guard/round/sticky digit count (legal 2..8).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, meaning the asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning the input operand is valid.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the unit accepts the operand this cycle.
REQ-007 SHALL have port in_sig, input, 4*DIGITS bits, meaning the unrounded BCD significand.
REQ-008 SHALL have port in_grs, input, 4*GRS_DIGITS bits, meaning the BCD digits below the significand LSD.
REQ-009 SHALL have port in_cout, input, 4 bits, meaning the BCD carry digit from the preceding adder (0 or 1).
REQ-010 SHALL have port in_sign, input, 1 bit, meaning the result sign (1 = negative).
REQ-011 SHALL have port in_mode, input, 3 bits, meaning rounding mode: 0 RNE, 1 RNA (ties away), 2 RTZ, 3 RUP (toward +inf), 4 RDN (toward -inf); codes 5-7 behave as RNE.
REQ-012 SHALL have port out_valid, input/output role output, 1 bit, meaning the result is valid.
REQ-013 SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-014 SHALL have port out_sig, output, 4*DIGITS bits, meaning the rounded BCD significand.
REQ-015 SHALL have port out_exp_inc, output, 2 bits, meaning the exponent increment (0..2) from normalisation plus round overflow.
REQ-016 SHALL have port out_inexact, output, 1 bit, meaning discarded digits were nonzero.
REQ-017 SHALL have port inexact_cnt, output, 16 bits, meaning the inexact-result counter (see Configuration).

Function
REQ-018 SHALL transfer an input on in_valid&&in_ready and an output on out_valid&&out_ready.
REQ-019 SHALL be a 2-stage pipeline: S1 normalise + round decision, S2 BCD increment; latency exactly 2 cycles with out_ready held high.
REQ-020 SHALL sustain one transfer per cycle; in_ready = !S1_valid || S1 advances; S1 advances when !S2_valid || out_ready.
REQ-021 SHALL, when in_cout==1, form sig = {in_cout, in_sig[MSD..digit1]} and rem = {in_sig LSD, in_grs upper GRS_DIGITS-1 digits}, setting shift=1; otherwise sig=in_sig, rem=in_grs, shift=0.
REQ-022 SHALL also OR the in_grs LSD lost in the shift into sticky.
REQ-023 SHALL define round digit = rem MSD, sticky = OR of all lower rem digits, inexact = (rem != 0).
REQ-024 SHALL increment when: RNE round>5 or (round==5 and (sticky or sig LSD odd)); RNA round>=5; RTZ never; RUP inexact&&!sign; RDN inexact&&sign.
REQ-025 SHALL, on increment of all-9 sig, output 1 followed by DIGITS-1 zeros and add 1 to out_exp_inc; inexact is unchanged.
REQ-026 SHALL set out_exp_inc = shift + overflow.
REQ-027 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-028 SHALL ignore in_* contents when in_valid is low; non-BCD digits produce unspecified out_sig but legal handshake.

Reset
REQ-029 SHALL on rst_n low asynchronously clear both stage valids, out_sig, out_exp_inc, out_inexact and inexact_cnt to 0; in_ready is 1 in reset.
REQ-030 SHALL discard in-flight operands on reset mid-operation; the first post-reset out_valid is the first operand accepted after release.

Configuration
REQ-031 SHALL with macro DRU_INEXACT_CNT_EN defined increment inexact_cnt by 1 per output transfer with out_inexact=1, saturating at 16'hFFFF.
REQ-032 SHALL without DRU_INEXACT_CNT_EN tie inexact_cnt to 0 and instantiate no counter flops.

Structure
REQ-033 SHALL take rounding-mode encodings (RM_RNE..RM_RDN), BCD_DIGIT_W=4 and the all-9/one digit constants from shared package dec_fp_pkg.
REQ-034 SHALL implement the S2 increment in one sub-module bcd_incrementer (DIGITS parameter, sum and carry-out).

Verification (DIGITS=7, GRS_DIGITS=3, values hex-BCD)
REQ-035 SHALL check RNE, sig 1234567, grs 500, cout 0 -> out_sig 1234568, exp_inc 0, inexact 1; sig 1234568 same grs -> 1234568.
REQ-036 SHALL check RNA, sig 9999999, grs 600 -> out_sig 1000000, exp_inc 1, inexact 1.
REQ-037 SHALL check RTZ, cout 1, sig 1234567, grs 000 -> out_sig 1123456, exp_inc 1, inexact 1.
REQ-038 SHALL check RUP/RDN, sig 0000001, grs 001: sign 0 RUP -> 0000002; sign 1 RUP -> 0000001; sign 1 RDN -> 0000002.
REQ-039 SHALL check 3 back-to-back inputs with out_ready low 4 cycles -> in_ready low after 2 accepted, no loss, in-order outputs after out_ready rises.
REQ-040 SHALL check rst_n pulse with both stages full -> out_valid 0 immediately, inexact_cnt 0, next output equals next accepted operand.
